// File: rtl/dmem_port.sv
// Data-memory port: turns a held pipeline memory request into one bus transfer.
// Responses are aligned and extended, and misaligned or timed-out accesses return an error.
module dmem_port #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [2:0]          req_dmtype,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                stall,
   output logic                rsp_valid,
   output logic                rsp_err,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_wea,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic [DATA_W-1:0]   bus_rdata,
   input  logic                bus_ready
);

   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [2:0]          dmtype_q, dmtype_d;
   logic [OFFW-1:0]     off_q, off_d;
   logic [NB-1:0]       wea_q, wea_d;
   logic [ADDR_W-1:0]   baddr_q, baddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [1:0]          sz;
   logic                bad_type, misalign;
   logic [NB-1:0]       lane_m;
   logic [DATA_W-1:0]   dmask;
   logic [OFFW-1:0]     req_off;
   logic [DATA_W-1:0]   sh, ld;

   assign req_off = req_addr[OFFW-1:0];

   // sz is log2 of the access size in bytes; lane_m is its unshifted lane mask
   always_comb begin
      sz       = 2'd0;
      bad_type = 1'b0;
      case (req_dmtype)
         3'b000:          sz = 2'd2;
         3'b001, 3'b010:  sz = 2'd1;
         3'b011, 3'b100:  sz = 2'd0;
         3'b101: begin
            sz       = 2'd3;
            bad_type = (DATA_W != 64);
         end
         default:         bad_type = 1'b1;
      endcase
      case (sz)
         2'd0:    lane_m = NB'(8'h01);
         2'd1:    lane_m = NB'(8'h03);
         2'd2:    lane_m = NB'(8'h0F);
         default: lane_m = NB'(8'hFF);
      endcase
      misalign = |(req_addr[2:0] & 3'((4'd1 << sz) - 4'd1));
      dmask    = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         dmask[8*b +: 8] = {8{lane_m[b]}};
      end
   end

   always_comb begin
      sh = bus_rdata >> {off_q, 3'b000};
      case (dmtype_q)
         3'b000:  ld = DATA_W'($signed(sh[31:0]));
         3'b001:  ld = DATA_W'($signed(sh[15:0]));
         3'b010:  ld = DATA_W'(sh[15:0]);
         3'b011:  ld = DATA_W'($signed(sh[7:0]));
         3'b100:  ld = DATA_W'(sh[7:0]);
         default: ld = sh;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      dmtype_d = dmtype_q;
      off_d    = off_q;
      wea_d    = wea_q;
      baddr_d  = baddr_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               rdata_d = '0;
               if (bad_type || misalign) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  we_d     = req_we;
                  dmtype_d = req_dmtype;
                  off_d    = req_off;
                  wea_d    = req_we ? (lane_m << req_off) : '0;
                  baddr_d  = {req_addr[ADDR_W-1:OFFW], OFFW'(0)};
                  wdata_d  = req_we ? ((req_wdata & dmask) << {req_off, 3'b000}) : '0;
                  cnt_d    = '0;
                  err_d    = 1'b0;
                  state_d  = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (bus_ready) begin
               rdata_d = we_q ? '0 : ld;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         dmtype_q <= '0;
         off_q    <= '0;
         wea_q    <= '0;
         baddr_q  <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         dmtype_q <= dmtype_d;
         off_q    <= off_d;
         wea_q    <= wea_d;
         baddr_q  <= baddr_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign bus_req   = (state_q == ACCESS);
   assign bus_we    = we_q;
   assign bus_wea   = wea_q;
   assign bus_addr  = baddr_q;
   assign bus_wdata = wdata_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = rsp_valid ? rdata_q : '0;
   assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=15) instance
// share stimulus; sel picks which one receives req_valid and is observed.
module tb_dmem_port;

   localparam int TO_A = 4;
   localparam int TO_B = 15;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sel, req_valid, req_we, bus_ready;
   logic [2:0]  req_dmtype;
   logic [31:0] req_addr;
   logic [63:0] req_wdata, bus_rdata;

   logic        stall_a, rv_a, re_a, breq_a, bwe_a;
   logic [31:0] rd_a, ba_a, bwd_a;
   logic [3:0]  wea_a;
   logic        stall_b, rv_b, re_b, breq_b, bwe_b;
   logic [63:0] rd_b, bwd_b;
   logic [31:0] ba_b;
   logic [7:0]  wea_b;

   dmem_port #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO_A)) dut32 (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_we(req_we),
      .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
      .stall(stall_a), .rsp_valid(rv_a), .rsp_err(re_a), .rsp_rdata(rd_a),
      .bus_req(breq_a), .bus_we(bwe_a), .bus_wea(wea_a), .bus_addr(ba_a),
      .bus_wdata(bwd_a), .bus_rdata(bus_rdata[31:0]), .bus_ready(bus_ready)
   );

   dmem_port #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO_B)) dut64 (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_we(req_we),
      .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall_b), .rsp_valid(rv_b), .rsp_err(re_b), .rsp_rdata(rd_b),
      .bus_req(breq_b), .bus_we(bwe_b), .bus_wea(wea_b), .bus_addr(ba_b),
      .bus_wdata(bwd_b), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   logic        o_stall, o_rv, o_re, o_breq, o_bwe;
   logic [63:0] o_rd, o_bwd;
   logic [31:0] o_ba;
   logic [7:0]  o_wea;
   assign o_stall = sel ? stall_b : stall_a;
   assign o_rv    = sel ? rv_b    : rv_a;
   assign o_re    = sel ? re_b    : re_a;
   assign o_breq  = sel ? breq_b  : breq_a;
   assign o_bwe   = sel ? bwe_b   : bwe_a;
   assign o_rd    = sel ? rd_b    : {32'h0, rd_a};
   assign o_bwd   = sel ? bwd_b   : {32'h0, bwd_a};
   assign o_ba    = sel ? ba_b    : ba_a;
   assign o_wea   = sel ? wea_b   : {4'h0, wea_a};

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        err;
      logic [63:0] rdata;
   } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      if (o_rv === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_err", {63'd0, o_re}, {63'd0, e.err});
            check("rsp_rdata", o_rd, e.rdata);
         end
      end
   end

   // Reference behaviour of one request, written from the access-type table
   function automatic void model(input bit s, input bit we, input logic [2:0] dt,
                                 input logic [31:0] addr, input logic [63:0] wd,
                                 input logic [63:0] rd, output bit merr,
                                 output logic [7:0] wea, output logic [31:0] ba,
                                 output logic [63:0] bwd, output logic [63:0] rdx);
      int          nb, size, off;
      logic [63:0] lmask, wmask, v;
      nb = s ? 8 : 4;
      case (dt)
         3'd0:       size = 4;
         3'd1, 3'd2: size = 2;
         3'd3, 3'd4: size = 1;
         3'd5:       size = s ? 8 : 0;
         default:    size = 0;
      endcase
      merr  = (size == 0) || ((addr % size) != 0);
      off   = int'(addr % nb);
      lmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (size * 8)) - 64'd1);
      wmask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      ba    = addr & ~32'(nb - 1);
      wea   = we ? 8'(((1 << size) - 1) << off) : 8'h00;
      bwd   = we ? (((wd & lmask) << (off * 8)) & wmask) : 64'h0;
      v     = (rd >> (off * 8)) & lmask;
      if ((dt == 3'd0 || dt == 3'd1 || dt == 3'd3) && size > 0 && size < 8 && v[size*8-1])
         v = v | ~lmask;
      rdx = we ? 64'h0 : (v & wmask);
   endfunction

   // Drives one request and follows it to its response; dly = wait cycles before
   // bus_ready (negative: never ready). b2b presents it during the previous RESP.
   task automatic do_req(input bit s, input bit b2b, input bit we, input logic [2:0] dt,
                         input logic [31:0] addr, input logic [63:0] wd,
                         input logic [63:0] rd, input int dly);
      bit          merr, in_resp, done;
      logic [7:0]  wea;
      logic [31:0] ba;
      logic [63:0] bwd, rdx;
      int          to, acc_exp, lat, k, acc, n;
      exp_t        e;
      model(s, we, dt, addr, wd, rd, merr, wea, ba, bwd, rdx);
      to = s ? TO_B : TO_A;
      if (merr)                     acc_exp = 0;
      else if (dly < 0 || dly >= to) acc_exp = to;
      else                          acc_exp = dly + 1;
      lat     = merr ? 1 : acc_exp + 1;
      e.err   = merr || (acc_exp == to && (dly < 0 || dly >= to));
      e.rdata = e.err ? 64'h0 : rdx;
      if (!b2b) @(negedge clk);
      in_resp    = (o_rv === 1'b1);
      sel        = s;
      req_we     = we;
      req_dmtype = dt;
      req_addr   = addr;
      req_wdata  = wd;
      bus_rdata  = rd;
      bus_ready  = 1'b0;
      req_valid  = 1'b1;
      sb.push_back(e);
      if (!in_resp) begin
         #1;
         check("stall_req", {63'd0, o_stall}, 64'd1);
      end
      k = 0; acc = 0; done = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
         if (o_breq) begin
            acc++;
            check("bus_addr", {32'd0, o_ba}, {32'd0, ba});
            check("bus_wea", {56'd0, o_wea}, {56'd0, wea});
            check("bus_wdata", o_bwd, bwd);
            check("bus_we", {63'd0, o_bwe}, {63'd0, we});
            bus_ready = (dly >= 0 && acc == dly + 1);
         end else begin
            bus_ready = 1'b0;
         end
         n = in_resp ? k - 1 : k;
         if (o_rv) begin
            check("latency", 64'(n), 64'(lat));
            check("stall_rsp", {63'd0, o_stall}, 64'd0);
            done = 1;
         end else begin
            check("stall_hold", {63'd0, o_stall}, 64'd1);
         end
      end
      if (!done) check("rsp_wait_expired", 64'd0, 64'd1);
      check("access_cycles", 64'(acc), 64'(acc_exp));
      req_valid = 1'b0;
      bus_ready = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_req"},   {63'd0, o_breq}, 64'd0);
      check({tag, "_we"},    {63'd0, o_bwe},  64'd0);
      check({tag, "_wea"},   {56'd0, o_wea},  64'd0);
      check({tag, "_addr"},  {32'd0, o_ba},   64'd0);
      check({tag, "_wdata"}, o_bwd,           64'd0);
      check({tag, "_rv"},    {63'd0, o_rv},   64'd0);
      check({tag, "_err"},   {63'd0, o_re},   64'd0);
      check({tag, "_rdata"}, o_rd,            64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; bus_ready = 1'b0;
      req_dmtype = '0; req_addr = '0; req_wdata = '0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = (i == 1);
         #1;
         check_quiet("reset");
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = (i == 1);
         #1;
         check_quiet("post_reset");
      end

      // 32-bit instance, TIMEOUT=4
      do_req(0, 0, 0, 3'b011, 32'h1003, 64'h0, 64'h80FF_0000, 0);
      do_req(0, 0, 1, 3'b001, 32'h2002, 64'h0000_BEEF, 64'h0, 3);
      do_req(0, 0, 0, 3'b000, 32'h3001, 64'h0, 64'h0, 0);
      do_req(0, 0, 0, 3'b000, 32'h0100, 64'h0, 64'h1234_5678, -1);
      do_req(0, 0, 0, 3'b000, 32'h0100, 64'h0, 64'h1234_5678, 3);
      do_req(0, 0, 0, 3'b010, 32'h0002, 64'h0, 64'h8001_0000, 1);
      do_req(0, 0, 0, 3'b001, 32'h0002, 64'h0, 64'h8001_0000, 0);
      do_req(0, 0, 0, 3'b101, 32'h0000, 64'h0, 64'h0, 0);
      do_req(0, 0, 0, 3'b111, 32'h0000, 64'h0, 64'h0, 0);
      do_req(0, 0, 1, 3'b000, 32'h0020, 64'hCAFE_F00D, 64'h0, 2);
      do_req(0, 0, 1, 3'b011, 32'h0011, 64'h0000_00A5, 64'h0, 0);
      do_req(0, 1, 0, 3'b100, 32'h0013, 64'h0, 64'hC300_0000, 0);

      // 64-bit instance, default TIMEOUT
      do_req(1, 0, 0, 3'b101, 32'h0008, 64'h0, 64'h8123_4567_89AB_CDEF, 0);
      do_req(1, 1, 0, 3'b100, 32'h000F, 64'h0, 64'hF000_0000_0000_0000, 0);
      do_req(1, 0, 0, 3'b000, 32'h0004, 64'h0, 64'h8000_0000_0000_0000, 2);
      do_req(1, 0, 1, 3'b101, 32'h0040, 64'h0123_4567_89AB_CDEF, 64'h0, 1);
      do_req(1, 0, 1, 3'b000, 32'h0044, 64'h0000_0000_DEAD_BEEF, 64'h0, 0);
      do_req(1, 0, 0, 3'b101, 32'h000C, 64'h0, 64'h0, 0);
      do_req(1, 0, 0, 3'b011, 32'h0005, 64'h0, 64'h0000_8000_0000_0000, -1);

      // reset during the second ACCESS cycle aborts the transfer
      @(negedge clk);
      sel = 1'b0; req_we = 1'b0; req_dmtype = 3'b000; req_addr = 32'h40;
      bus_rdata = 64'h5555_AAAA; bus_ready = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      check("abort_access1", {63'd0, o_breq}, 64'd1);
      @(negedge clk);
      check("abort_access2", {63'd0, o_breq}, 64'd1);
      rst = 1'b1; req_valid = 1'b0;
      @(negedge clk);
      check_quiet("abort");
      check("abort_stall", {63'd0, o_stall}, 64'd0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rsp", {63'd0, o_rv}, 64'd0);
      end
      do_req(0, 0, 0, 3'b000, 32'h0040, 64'h0, 64'h5555_AAAA, 0);

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter DATA_W, default 32, meaning data bus width; legal values 32 or 64 only.
REQ-002 Parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 Parameter TIMEOUT, default 15, meaning maximum ACCESS-state cycles without bus_ready before an error response; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  memory-stage request present; held stable by the pipeline until rsp_valid.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_dmtype  input  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned, 101 doubleword (DATA_W=64 only).
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  DATA_W  store data, right-aligned.
REQ-011 stall  output  1  pipeline hold, combinational.
REQ-012 rsp_valid, rsp_err  output  1 each  response strobe, error flag.
REQ-013 rsp_rdata  output  DATA_W  load data, extended per dmtype.
REQ-014 bus_req, bus_we  output  1 each  bus request, write enable.
REQ-015 bus_wea  output  DATA_W/8  byte-lane enables.
REQ-016 bus_addr  output  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero).
REQ-017 bus_wdata  output  DATA_W  store data shifted to its lanes.
REQ-018 bus_rdata  input  DATA_W; bus_ready  input  1  read data and completion, sampled only in ACCESS.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-020 IDLE with req_valid=1 and aligned address SHALL latch request fields and go to ACCESS next edge.
REQ-021 Misalignment (half: addr[0]!=0; word: addr[1:0]!=0; doubleword: addr[2:0]!=0; dmtype 101 with DATA_W=32 or dmtype 110/111) SHALL go IDLE->RESP with rsp_err=1 and no bus_req.
REQ-022 In ACCESS, bus_req=1 and bus_we/bus_wea/bus_addr/bus_wdata SHALL stay constant from latched fields.
REQ-023 bus_wea SHALL set 1 lane for byte, 2 for half, 4 for word, 8 for doubleword, positioned by addr offset; all-zero for loads.
REQ-024 ACCESS with bus_ready=1 SHALL capture bus_rdata and go to RESP next edge.
REQ-025 Cycle counter SHALL clear on ACCESS entry and increment per ACCESS cycle; bus_ready=0 on the TIMEOUT-th cycle SHALL go to RESP with rsp_err=1, rsp_rdata=0.
REQ-026 bus_ready=1 on the TIMEOUT-th cycle SHALL count as success, not timeout.
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-028 Loads SHALL shift the selected lanes to bit 0; 001/011 sign-extend, 010/100 zero-extend; word on DATA_W=64 sign-extends.
REQ-029 Stores SHALL give rsp_rdata=0.
REQ-030 stall SHALL equal req_valid & ~rsp_valid.
REQ-031 Minimum latency, ready in the first ACCESS cycle: request at cycle N, rsp_valid at N+2, stall high N..N+1.
REQ-032 req_valid remaining high in IDLE after RESP SHALL be treated as a new request.
REQ-033 Request inputs SHALL be ignored outside IDLE.
REQ-034 bus_ready outside ACCESS SHALL be ignored.

Reset
REQ-035 rst=1 at a rising edge SHALL force IDLE, counter 0, and latched fields 0.
REQ-036 During and after reset, until a new request: bus_req=0, bus_we=0, bus_wea=0, bus_addr=0, bus_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-037 Reset in ACCESS or RESP SHALL abort the transfer: bus_req low and no rsp_valid after that edge.

Verification
REQ-038 Load byte, DATA_W=32, addr 0x1003, bus_rdata 0x80FF_0000 with ready in the first ACCESS cycle -> bus_addr 0x1000, wea 0000, rsp_rdata 0xFFFF_FF80 at N+2.
REQ-039 Store half 0xBEEF, addr 0x2002, ready after 3 wait cycles -> wea 1100, bus_wdata 0xBEEF_0000 stable 4 cycles, stall high N..N+4.
REQ-040 Load word, addr 0x3001 -> rsp_valid and rsp_err at N+1, bus_req never high.
REQ-041 TIMEOUT=4, bus_ready held 0 -> bus_req high 4 cycles, rsp_err=1, rsp_rdata=0; repeat with ready on cycle 4 -> rsp_err=0.
REQ-042 DATA_W=64, load doubleword 0x8, then byte-unsigned at 0xF back-to-back -> both correct, second request accepted the cycle after the first RESP.
REQ-043 rst asserted in the second ACCESS cycle -> all outputs 0 next cycle, no rsp_valid, next request served normally.
